// File: rtl/vga_sync_receiver.sv
// Receive-side VGA sync tracker: measures incoming hSync/vSync timing, locks once the
// raster matches the expected geometry, and regenerates aligned pixel/line counters.
module vga_sync_receiver #(
    parameter int   H_TOTAL        = 800,
    parameter int   H_PULSE        = 128,
    parameter int   V_TOTAL        = 521,
    parameter int   V_PULSE        = 2,
    parameter int   H_ACTIVE_START = 144,
    parameter int   H_ACTIVE_END   = 784,
    parameter int   V_ACTIVE_START = 31,
    parameter int   V_ACTIVE_END   = 511,
    parameter logic H_ACTIVE_LEVEL = 1'b0,
    parameter logic V_ACTIVE_LEVEL = 1'b1,
    parameter int   LOCK_FRAMES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hSyncIn,
    input  logic       vSyncIn,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       vidOn,
    output logic       locked,
    output logic       lockLost,
    output logic [9:0] measHTotal,
    output logic [9:0] measVTotal
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [9:0] CNT_MAX   = 10'd1023;

    logic [2:0]  h_sync_q, h_sync_d;
    logic [2:0]  v_sync_q, v_sync_d;
    logic [9:0]  h_count_q, h_count_d;
    logic [9:0]  v_count_q, v_count_d;
    logic [9:0]  meas_h_q, meas_h_d;
    logic [9:0]  meas_v_q, meas_v_d;
    logic [9:0]  h_pulse_q, h_pulse_d;
    logic [9:0]  v_pulse_q, v_pulse_d;
    logic [3:0]  good_q, good_d;
    logic [1:0]  state_q, state_d;
    logic        locked_q, locked_d;
    logic        lock_lost_q, lock_lost_d;

    logic        h_act_s2, h_act_s3, v_act_s2, v_act_s3;
    logic        h_edge, h_trail, v_edge, v_trail;
    logic        h_timeout, v_timeout, timeout;
    logic        line_ok, frame_ok, line_fail, frame_fail;
    logic [10:0] h_count_inc, v_count_inc;
    logic [3:0]  good_inc;

    always_comb begin
        h_sync_d    = {h_sync_q[1:0], hSyncIn};
        v_sync_d    = {v_sync_q[1:0], vSyncIn};
        h_act_s2    = (h_sync_q[1] == H_ACTIVE_LEVEL);
        h_act_s3    = (h_sync_q[2] == H_ACTIVE_LEVEL);
        v_act_s2    = (v_sync_q[1] == V_ACTIVE_LEVEL);
        v_act_s3    = (v_sync_q[2] == V_ACTIVE_LEVEL);
        h_edge      = h_act_s2 && !h_act_s3;
        h_trail     = !h_act_s2 && h_act_s3;
        v_edge      = v_act_s2 && !v_act_s3;
        v_trail     = !v_act_s2 && v_act_s3;
        h_timeout   = (h_count_q == CNT_MAX);
        v_timeout   = (v_count_q == CNT_MAX);
        timeout     = h_timeout || v_timeout;
        // Sums are one bit wider so a saturated counter never aliases to a small length.
        h_count_inc = {1'b0, h_count_q} + 11'd1;
        v_count_inc = {1'b0, v_count_q} + 11'd1;
        line_ok     = (h_count_inc == 11'(H_TOTAL)) && (h_pulse_q == 10'(H_PULSE));
        frame_ok    = (v_count_inc == 11'(V_TOTAL)) && (v_pulse_q == 10'(V_PULSE));
        line_fail   = h_edge && !line_ok;
        frame_fail  = v_edge && !frame_ok;
        good_inc    = good_q + 4'd1;
    end

    always_comb begin
        h_count_d = h_edge ? 10'd0 : (h_timeout ? h_count_q : h_count_q + 10'd1);
        if (v_edge) begin
            v_count_d = 10'd0;
        end else if (h_edge && !v_timeout) begin
            v_count_d = v_count_q + 10'd1;
        end else begin
            v_count_d = v_count_q;
        end
        meas_h_d  = h_edge  ? h_count_inc[9:0] : meas_h_q;
        h_pulse_d = h_trail ? h_count_inc[9:0] : h_pulse_q;
        meas_v_d  = v_edge  ? v_count_inc[9:0] : meas_v_q;
        v_pulse_d = v_trail ? v_count_inc[9:0] : v_pulse_q;
    end

    // A line failure outranks a coincident vEdge, so it is tested first in CHECK.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            ST_SEARCH: begin
                if (v_edge) begin
                    state_d = ST_CHECK;
                    good_d  = 4'd0;
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_CHECK: begin
                if (line_fail || timeout) begin
                    state_d = ST_SEARCH;
                end else if (v_edge && frame_ok) begin
                    good_d  = good_inc;
                    state_d = (good_inc >= 4'(LOCK_FRAMES)) ? ST_LOCKED : ST_CHECK;
                end else if (v_edge) begin
                    good_d = 4'd0;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_LOCKED: begin
                if (line_fail || frame_fail || timeout) begin
                    state_d = ST_SEARCH;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                good_d  = 4'd0;
            end
        endcase
        locked_d    = (state_d == ST_LOCKED);
        lock_lost_d = (state_q == ST_LOCKED) && (state_d == ST_SEARCH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_sync_q    <= {3{~H_ACTIVE_LEVEL}};
            v_sync_q    <= {3{~V_ACTIVE_LEVEL}};
            h_count_q   <= 10'd0;
            v_count_q   <= 10'd0;
            meas_h_q    <= 10'd0;
            meas_v_q    <= 10'd0;
            h_pulse_q   <= 10'd0;
            v_pulse_q   <= 10'd0;
            good_q      <= 4'd0;
            state_q     <= ST_SEARCH;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            h_sync_q    <= h_sync_d;
            v_sync_q    <= v_sync_d;
            h_count_q   <= h_count_d;
            v_count_q   <= v_count_d;
            meas_h_q    <= meas_h_d;
            meas_v_q    <= meas_v_d;
            h_pulse_q   <= h_pulse_d;
            v_pulse_q   <= v_pulse_d;
            good_q      <= good_d;
            state_q     <= state_d;
            locked_q    <= locked_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign hCount     = h_count_q;
    assign vCount     = v_count_q;
    assign measHTotal = meas_h_q;
    assign measVTotal = meas_v_q;
    assign locked     = locked_q;
    assign lockLost   = lock_lost_q;
    assign vidOn      = locked_q
                        && (h_count_q >= 10'(H_ACTIVE_START)) && (h_count_q < 10'(H_ACTIVE_END))
                        && (v_count_q >= 10'(V_ACTIVE_START)) && (v_count_q < 10'(V_ACTIVE_END));

endmodule
